// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port SRAM access arbiter: FSM states, port
// indices, grant codes and request direction.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_A = 2'b01,
    ST_BUSY_B = 2'b10
  } arb_state_t;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  function automatic logic [1:0] grant_of(arb_state_t st);
    case (st)
      ST_BUSY_A: return GRANT_A;
      ST_BUSY_B: return GRANT_B;
      default:   return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_req_latch.sv
// One requester's pending slot: captures a begin pulse into a single-entry
// latch and flags protocol violations (sticky) without disturbing held state.
module mem_req_latch
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              begin_wr,
  input  logic              begin_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_wr,
  input  logic              busy,
  input  logic              take,
  output logic              valid,
  output logic              dir,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [7:0]        pend_data,
  output logic              err
);

  logic any_begin, bad, load;

  // busy already excludes the cycle in which this port's transaction finishes
  assign any_begin = begin_wr | begin_rd;
  assign bad       = (begin_wr & begin_rd) | (any_begin & (valid | busy));
  assign load      = any_begin & ~bad;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      dir       <= DIR_WR;
      pend_addr <= '0;
      pend_data <= '0;
      err       <= 1'b0;
    end else begin
      if (bad) err <= 1'b1;
      if (load) begin
        valid     <= 1'b1;
        dir       <= begin_rd ? DIR_RD : DIR_WR;
        pend_addr <= addr;
        pend_data <= data_wr;
      end else if (take) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram_ctrl port between a latency-critical requester (A) and a
// bulk requester (B); A has priority, bounded by a starvation streak for B.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 20
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              a_begin_wr,
  input  logic              a_begin_rd,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_data_wr,
  output logic [7:0]        a_data_rd,
  output logic              a_finish,
  input  logic              b_begin_wr,
  input  logic              b_begin_rd,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_data_wr,
  output logic [7:0]        b_data_rd,
  output logic              b_finish,
  output logic              m_begin_wr,
  output logic              m_begin_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_data_wr,
  input  logic [7:0]        m_data_rd,
  input  logic              m_finish,
  output logic [1:0]        grant,
  output logic [1:0]        err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t        state, state_next;
  logic [1:0]        pend_valid, pend_dir, lat_err, busy, take;
  logic [ADDR_W-1:0] pend_addr [2];
  logic [7:0]        pend_data [2];
  logic [3:0]        streak;
  logic              cur_rd, pick_a, pick_b, win_dir;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_data;

  assign busy[PORT_A] = (state == ST_BUSY_A) && !m_finish;
  assign busy[PORT_B] = (state == ST_BUSY_B) && !m_finish;
  assign take[PORT_A] = pick_a;
  assign take[PORT_B] = pick_b;
  assign err          = lat_err;

  mem_req_latch #(.ADDR_W(ADDR_W)) u_latch_a (
    .mclk(mclk), .reset(reset),
    .begin_wr(a_begin_wr), .begin_rd(a_begin_rd), .addr(a_addr), .data_wr(a_data_wr),
    .busy(busy[PORT_A]), .take(take[PORT_A]),
    .valid(pend_valid[PORT_A]), .dir(pend_dir[PORT_A]),
    .pend_addr(pend_addr[PORT_A]), .pend_data(pend_data[PORT_A]), .err(lat_err[PORT_A])
  );

  mem_req_latch #(.ADDR_W(ADDR_W)) u_latch_b (
    .mclk(mclk), .reset(reset),
    .begin_wr(b_begin_wr), .begin_rd(b_begin_rd), .addr(b_addr), .data_wr(b_data_wr),
    .busy(busy[PORT_B]), .take(take[PORT_B]),
    .valid(pend_valid[PORT_B]), .dir(pend_dir[PORT_B]),
    .pend_addr(pend_addr[PORT_B]), .pend_data(pend_data[PORT_B]), .err(lat_err[PORT_B])
  );

  always_comb begin
    state_next = state;
    pick_a     = 1'b0;
    pick_b     = 1'b0;
    case (state)
      ST_IDLE: begin
        // B overrides A only once A has won LIMIT times in a row over a waiting B
        if (pend_valid[PORT_A] && !(pend_valid[PORT_B] && streak == LIMIT)) begin
          pick_a     = 1'b1;
          state_next = ST_BUSY_A;
        end else if (pend_valid[PORT_B]) begin
          pick_b     = 1'b1;
          state_next = ST_BUSY_B;
        end
      end
      ST_BUSY_A, ST_BUSY_B: if (m_finish) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    win_dir  = pick_b ? pend_dir[PORT_B]  : pend_dir[PORT_A];
    win_addr = pick_b ? pend_addr[PORT_B] : pend_addr[PORT_A];
    win_data = pick_b ? pend_data[PORT_B] : pend_data[PORT_A];
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= GRANT_NONE;
      streak     <= '0;
      cur_rd     <= 1'b0;
      m_begin_wr <= 1'b0;
      m_begin_rd <= 1'b0;
      m_addr     <= '0;
      m_data_wr  <= '0;
      a_finish   <= 1'b0;
      b_finish   <= 1'b0;
      a_data_rd  <= '0;
      b_data_rd  <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_of(state_next);
      m_begin_wr <= 1'b0;
      m_begin_rd <= 1'b0;
      a_finish   <= 1'b0;
      b_finish   <= 1'b0;
      if (pick_a || pick_b) begin
        m_addr     <= win_addr;
        m_data_wr  <= win_data;
        m_begin_rd <= (win_dir == DIR_RD);
        m_begin_wr <= (win_dir == DIR_WR);
        cur_rd     <= (win_dir == DIR_RD);
      end
      if (pick_b || (pick_a && !pend_valid[PORT_B])) streak <= '0;
      else if (pick_a && streak != LIMIT)            streak <= streak + 4'd1;
      if (m_finish && state == ST_BUSY_A) begin
        a_finish <= 1'b1;
        if (cur_rd) a_data_rd <= m_data_rd;
      end
      if (m_finish && state == ST_BUSY_B) begin
        b_finish <= 1'b1;
        if (cur_rd) b_data_rd <= m_data_rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level
// reference model and a behavioural sram_ctrl responder.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 20;
  localparam int LIMIT  = 4;

  logic              mclk = 1'b0;
  logic              reset = 1'b0;
  logic              bw [2];
  logic              br [2];
  logic [ADDR_W-1:0] req_addr [2];
  logic [7:0]        req_data [2];
  logic [7:0]        a_data_rd, b_data_rd, m_data_wr;
  logic [7:0]        m_data_rd = 8'h00;
  logic              a_finish, b_finish, m_begin_wr, m_begin_rd;
  logic              m_finish = 1'b0;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        grant, err;

  always #5 mclk = ~mclk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(ADDR_W)) dut (
    .mclk(mclk), .reset(reset),
    .a_begin_wr(bw[0]), .a_begin_rd(br[0]), .a_addr(req_addr[0]), .a_data_wr(req_data[0]),
    .a_data_rd(a_data_rd), .a_finish(a_finish),
    .b_begin_wr(bw[1]), .b_begin_rd(br[1]), .b_addr(req_addr[1]), .b_data_wr(req_data[1]),
    .b_data_rd(b_data_rd), .b_finish(b_finish),
    .m_begin_wr(m_begin_wr), .m_begin_rd(m_begin_rd), .m_addr(m_addr), .m_data_wr(m_data_wr),
    .m_data_rd(m_data_rd), .m_finish(m_finish), .grant(grant), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit                valid;
    bit                rd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } req_t;

  req_t              pend [2];
  int                owner;
  bit                owner_rd;
  int                streak_m;
  bit   [1:0]        e_err;
  logic [7:0]        e_rd [2];
  bit                e_fin [2];
  bit                e_mbw, e_mbr;
  logic [ADDR_W-1:0] e_maddr;
  logic [7:0]        e_mdata;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p].valid = 0;
      e_rd[p]       = 8'h00;
      e_fin[p]      = 0;
    end
    owner    = -1;
    owner_rd = 0;
    streak_m = 0;
    e_err    = 2'b00;
    e_mbw    = 0;
    e_mbr    = 0;
    e_maddr  = '0;
    e_mdata  = 8'h00;
  endtask

  // Applies one clock edge using the requester/downstream inputs present at it.
  task automatic model_edge();
    bit load [2];
    int w;
    bit fin_now;
    fin_now = (owner >= 0) && m_finish;
    e_mbw = 0; e_mbr = 0; e_fin[0] = 0; e_fin[1] = 0;
    for (int p = 0; p < 2; p++) begin
      load[p] = 0;
      if (bw[p] || br[p]) begin
        if ((bw[p] && br[p]) || pend[p].valid || (owner == p && !fin_now)) e_err[p] = 1;
        else load[p] = 1;
      end
    end
    if (owner < 0) begin
      w = -1;
      if (pend[0].valid && !(pend[1].valid && streak_m == LIMIT)) w = 0;
      else if (pend[1].valid) w = 1;
      if (w >= 0) begin
        if (w == 0 && pend[1].valid) streak_m = (streak_m < LIMIT) ? streak_m + 1 : LIMIT;
        else streak_m = 0;
        e_maddr = pend[w].addr;
        e_mdata = pend[w].data;
        e_mbr   = pend[w].rd;
        e_mbw   = !pend[w].rd;
        owner   = w;
        owner_rd = pend[w].rd;
        pend[w].valid = 0;
      end
    end else if (m_finish) begin
      e_fin[owner] = 1;
      if (owner_rd) e_rd[owner] = m_data_rd;
      owner = -1;
    end
    for (int p = 0; p < 2; p++)
      if (load[p]) pend[p] = '{valid: 1'b1, rd: br[p], addr: req_addr[p], data: req_data[p]};
  endtask

  function automatic logic [1:0] exp_grant();
    return (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- downstream sram_ctrl responder ----------------
  logic [7:0]        mem [logic [ADDR_W-1:0]];
  int                ds_cnt = 0;
  int                ds_delay = 0;
  bit                ds_rd;
  logic [ADDR_W-1:0] ds_addr;
  logic [7:0]        ds_data;
  int                begin_cnt = 0;
  logic [1:0]        grant_log [$];

  function automatic logic [7:0] mem_rd(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = a[7:0] ^ 8'h3C;
    if (mem.exists(a)) v = mem[a];
    return v;
  endfunction

  task automatic ds_step();
    m_finish  = 1'b0;
    m_data_rd = 8'($urandom);
    if (ds_cnt > 0) begin
      ds_cnt--;
      if (ds_cnt == 0) begin
        m_finish = 1'b1;
        if (ds_rd) m_data_rd = mem_rd(ds_addr);
        else mem[ds_addr] = ds_data;
      end
    end else if (m_begin_wr || m_begin_rd) begin
      ds_cnt  = (ds_delay > 0) ? ds_delay : $urandom_range(1, 5);
      ds_rd   = m_begin_rd;
      ds_addr = m_addr;
      ds_data = m_data_wr;
      begin_cnt++;
      grant_log.push_back(grant);
    end
  endtask

  // ---------------- per-cycle engine ----------------
  int cyc = 0;
  int n_fin [2];
  bit auto_a = 0;

  task automatic step();
    @(posedge mclk);
    #1;
    model_edge();
    cyc++;
    chk("ctrl", {grant, err, a_finish, b_finish, m_begin_wr, m_begin_rd},
        {exp_grant(), e_err, e_fin[0], e_fin[1], e_mbw, e_mbr});
    chk("m_addr_data", {m_addr, m_data_wr}, {e_maddr, e_mdata});
    chk("data_rd", {a_data_rd, b_data_rd}, {e_rd[0], e_rd[1]});
    if (a_finish) n_fin[0]++;
    if (b_finish) n_fin[1]++;
    for (int p = 0; p < 2; p++) begin
      bw[p] = 1'b0;
      br[p] = 1'b0;
    end
    ds_step();
    // A re-requests in its own finish cycle to keep it back-to-back
    if (auto_a && m_finish && grant == 2'b01) begin
      br[0]       = 1'b1;
      req_addr[0] = 20'h00400 + ADDR_W'(cyc[7:0]);
    end
  endtask

  task automatic do_reset(input bit keep_ds);
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs",
        {a_data_rd, b_data_rd, a_finish, b_finish, m_begin_wr, m_begin_rd, m_addr, m_data_wr, grant, err},
        64'd0);
    model_reset();
    if (!keep_ds) begin
      ds_cnt   = 0;
      m_finish = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      bw[p] = 1'b0;
      br[p] = 1'b0;
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_fin_cyc, b_beg_cyc, snap, r;
    logic [11:0] seq;
    for (int p = 0; p < 2; p++) begin
      bw[p] = 1'b0; br[p] = 1'b0; req_addr[p] = '0; req_data[p] = 8'h00;
    end
    n_fin[0] = 0; n_fin[1] = 0;
    do_reset(0);

    // single A read
    mem[20'h00123] = 8'h5A;
    ds_delay = 4;
    br[0] = 1'b1; req_addr[0] = 20'h00123; req_data[0] = 8'h77;
    step();
    step();
    chk("a_rd_issue", {m_begin_rd, m_begin_wr}, 2'b10);
    for (int i = 0; i < 20 && n_fin[0] == 0; i++) step();
    step(); step();
    chk("a_fin_count", 64'(n_fin[0]), 64'd1);
    chk("b_fin_none", 64'(n_fin[1]), 64'd0);
    chk("a_rd_data", 64'(a_data_rd), 64'h5A);

    // simultaneous A write and B read
    n_fin[0] = 0; n_fin[1] = 0;
    grant_log.delete();
    ds_delay = 3;
    a_fin_cyc = -1; b_beg_cyc = -1;
    bw[0] = 1'b1; req_addr[0] = 20'h00010; req_data[0] = 8'hC3;
    br[1] = 1'b1; req_addr[1] = 20'h80000; req_data[1] = 8'h11;
    for (int i = 0; i < 40 && n_fin[1] == 0; i++) begin
      step();
      if (a_finish && a_fin_cyc < 0) a_fin_cyc = cyc;
      if (m_begin_rd && grant == 2'b10 && b_beg_cyc < 0) b_beg_cyc = cyc;
    end
    if (grant_log.size() == 2) chk("ab_order", {grant_log[0], grant_log[1]}, {2'b01, 2'b10});
    else chk("ab_grant_count", 64'(grant_log.size()), 64'd2);
    chk("b_after_a_gap", 64'(b_beg_cyc - a_fin_cyc), 64'd1);
    chk("a_wr_keeps_rd", 64'(a_data_rd), 64'h5A);
    chk("a_wr_mem", 64'(mem_rd(20'h00010)), 64'hC3);

    // starvation bound
    grant_log.delete();
    ds_delay = 2;
    auto_a = 1;
    br[0] = 1'b1; req_addr[0] = 20'h00400;
    br[1] = 1'b1; req_addr[1] = 20'h80100;
    for (int i = 0; i < 120 && grant_log.size() < 6; i++) begin
      step();
      if (grant_log.size() >= 5) auto_a = 0;
    end
    auto_a = 0;
    for (int i = 0; i < 10; i++) step();
    seq = 12'h000;
    for (int i = 0; i < 6 && i < grant_log.size(); i++) seq[11 - 2*i -: 2] = grant_log[i];
    chk("starve_grants", 64'(grant_log.size()), 64'd6);
    chk("starve_order", 64'(seq), 64'({2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01}));

    // protocol errors
    ds_delay = 5;
    snap = begin_cnt;
    br[0] = 1'b1; req_addr[0] = 20'h00200;
    step(); step(); step();
    br[0] = 1'b1; req_addr[0] = 20'h00201;
    step();
    chk("err_a_inflight", 64'(err), 64'b01);
    for (int i = 0; i < 12; i++) step();
    chk("err_a_one_access", 64'(begin_cnt - snap), 64'd1);
    bw[1] = 1'b1; br[1] = 1'b1; req_addr[1] = 20'h80200;
    step();
    chk("err_b_both", 64'(err), 64'b11);
    for (int i = 0; i < 4; i++) step();
    chk("err_b_no_access", 64'(begin_cnt - snap), 64'd1);

    // reset while B is in flight, late downstream finish afterwards
    do_reset(0);
    ds_delay = 6;
    br[1] = 1'b1; req_addr[1] = 20'h00300;
    step(); step(); step();
    chk("busy_b", 64'(grant), 64'b10);
    do_reset(1);
    n_fin[0] = 0; n_fin[1] = 0;
    for (int i = 0; i < 10; i++) step();
    chk("late_fin_ignored", 64'(n_fin[0] + n_fin[1]), 64'd0);

    // randomized traffic
    do_reset(0);
    ds_delay = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset(0);
      for (int p = 0; p < 2; p++) begin
        r = $urandom_range(0, 99);
        if (r < 25) begin
          req_addr[p] = ADDR_W'($urandom_range(0, 63));
          req_data[p] = 8'($urandom);
          if (r < 1) begin bw[p] = 1'b1; br[p] = 1'b1; end
          else if (r < 13) br[p] = 1'b1;
          else bw[p] = 1'b1;
        end
      end
      step();
      if (ds_cnt == 0 && !m_finish && grant == 2'b00 && !m_begin_wr && !m_begin_rd
          && $urandom_range(0, 99) < 3)
        m_finish = 1'b1;
    end
    for (int i = 0; i < 12; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
